// File: rtl/timetag_event_latch.sv
// timetag_event_latch: photon time-tagger back end.
// Extends the upstream 2-bit fine count with a coarse counter advanced by the
// fine stage's carry pulse. Synchronizes and rising-edge detects NCH photon
// channels, packs each hit into {coarse, fine, mask}, and buffers the tags in a
// first-word-fall-through FIFO read with a valid/ready handshake.
//
// Ports:
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   enable       1 = tagging and coarse counting active
//   fine_count   fine count from the upstream counter stage
//   carry_in     one-cycle carry pulse from the upstream counter stage
//   ch_in        asynchronous photon pulses, active high
//   tag_data     head-of-FIFO word {coarse, fine, mask}
//   tag_valid    FIFO not empty
//   tag_ready    consumer accepts tag_data when tag_valid=1
//   overflow     sticky flag, a word was dropped
//   ovf_clr      one-cycle pulse that clears overflow
//   fill_level   current FIFO occupancy
module timetag_event_latch #(
  parameter int unsigned NCH   = 4,
  parameter int unsigned CW    = 30,
  parameter int unsigned DEPTH = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic [1:0]                fine_count,
  input  logic                      carry_in,
  input  logic [NCH-1:0]            ch_in,
  output logic [CW+2+NCH-1:0]       tag_data,
  output logic                      tag_valid,
  input  logic                      tag_ready,
  output logic                      overflow,
  input  logic                      ovf_clr,
  output logic [$clog2(DEPTH):0]    fill_level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned TW = CW + 2 + NCH;

  logic [NCH-1:0] s1_q, s2_q, p_q;
  logic [CW-1:0]  coarse_q, coarse_d;
  logic           marker_q, marker_d;
  logic           ovf_q, ovf_d;
  logic [TW-1:0]  mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]  cnt_q, cnt_d;
  logic [TW-1:0]  head_q, head_d;
  logic           valid_q, valid_d;

  logic [NCH-1:0] hit_c;
  logic           hit_wr_c, mk_wr_c, wr_req_c, wr_acc_c, drop_c;
  logic           pop_c, full_c, rollover_c;
  logic [TW-1:0]  wr_word_c;

  // Write selection, FIFO bookkeeping and flag next-state.
  always_comb begin
    hit_c      = s2_q & ~p_q;
    hit_wr_c   = enable & (|hit_c);
    mk_wr_c    = ~hit_wr_c & marker_q;
    wr_req_c   = hit_wr_c | mk_wr_c;
    wr_word_c  = '0;
    if (hit_wr_c) begin
      wr_word_c = {coarse_q, fine_count, hit_c};
    end

    // Full is judged on the occupancy at the start of the cycle, so a
    // same-cycle pop does not make room for the incoming word.
    full_c     = (cnt_q == LW'(DEPTH));
    pop_c      = valid_q & tag_ready;
    wr_acc_c   = wr_req_c & ~full_c;
    drop_c     = wr_req_c & full_c;

    rollover_c = enable & carry_in & (&coarse_q);
    coarse_d   = coarse_q + CW'(enable & carry_in);

    // A rollover in the cycle the marker is written re-arms it.
    marker_d = marker_q;
    if (mk_wr_c) begin
      marker_d = 1'b0;
    end
    if (rollover_c) begin
      marker_d = 1'b1;
    end

    ovf_d = ovf_q;
    if (ovf_clr) begin
      ovf_d = 1'b0;
    end
    if (drop_c) begin
      ovf_d = 1'b1;
    end

    cnt_d    = cnt_q + LW'(wr_acc_c) - LW'(pop_c);
    rd_ptr_d = rd_ptr_q + AW'(pop_c);
    wr_ptr_d = wr_ptr_q + AW'(wr_acc_c);
    valid_d  = (cnt_d != '0);

    // Registered head: bypass the incoming word when it lands at the new head.
    head_d = '0;
    if (valid_d) begin
      if (wr_acc_c && (wr_ptr_q == rd_ptr_d)) begin
        head_d = wr_word_c;
      end else begin
        head_d = mem_q[rd_ptr_d];
      end
    end
  end

  // Synchronizers, coarse counter, flags and FIFO control state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q     <= '0;
      s2_q     <= '0;
      p_q      <= '0;
      coarse_q <= '0;
      marker_q <= 1'b0;
      ovf_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      head_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      s1_q     <= ch_in;
      s2_q     <= s1_q;
      p_q      <= s2_q;
      coarse_q <= coarse_d;
      marker_q <= marker_d;
      ovf_q    <= ovf_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      head_q   <= head_d;
      valid_q  <= valid_d;
    end
  end

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (wr_acc_c) begin
      mem_q[wr_ptr_q] <= wr_word_c;
    end
  end

  assign tag_data   = head_q;
  assign tag_valid  = valid_q;
  assign overflow   = ovf_q;
  assign fill_level = cnt_q;

endmodule
